soc_bus_fabric: RTL

- Parametrised CPU-to-system bus fabric; successor to the shared bidirectional data/rw bus between CPU and memory.
- Separate read and write data paths with a req/ready handshake to the CPU.
- Decodes each access to external memory, an internal memory-mapped LED register, or an unmapped error.
- Supports variable-latency memory with an ack handshake, and an optional watchdog timeout.

---
 rtl/soc_bus_fabric.sv | 133 +++++++++++++
 1 files changed

// File: rtl/soc_bus_fabric.sv
// rtl/soc_bus_fabric.sv - CPU-to-system bus fabric: memory / LED register / error decode
// Optional watchdog on memory accesses: define SOC_BUS_TIMEOUT_EN.
module soc_bus_fabric #(
  parameter int                 ADDR_W         = 64,
  parameter int                 DATA_W         = 64,
  parameter int                 MEM_BYTES      = 4096,
  parameter logic [ADDR_W-1:0]  LED_ADDR       = ADDR_W'(64'hFFFF_FFFF_FFFF_FF00),
  parameter logic [DATA_W-1:0]  LED_RESET      = '0,
  parameter int                 TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] LED
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MEM  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);
  localparam logic [ADDR_W-1:0] MEM_LIMIT  = ADDR_W'(MEM_BYTES);

  if (DATA_W < 8 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
    $error("soc_bus_fabric: DATA_W must be a power of two >= 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("soc_bus_fabric: TIMEOUT_CYCLES must be >= 1");
  end
  if (LED_ADDR < MEM_LIMIT) begin : g_bad_led_addr
    $error("soc_bus_fabric: LED_ADDR must lie outside the memory region");
  end

  logic [1:0]        state;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] led_q;

  logic misaligned;
  assign misaligned = |(cpu_addr & ALIGN_MASK);

`ifdef SOC_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
`endif

  // mem_* registers double as the latched copy of the CPU request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      led_q     <= LED_RESET;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef SOC_BUS_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (misaligned) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= RESP;
            end else if (cpu_addr == LED_ADDR) begin
              err_q <= 1'b0;
              if (cpu_we) led_q   <= cpu_wdata;
              else        rdata_q <= led_q;
              state <= RESP;
            end else if (cpu_addr < MEM_LIMIT) begin
              mem_req   <= 1'b1;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
`ifdef SOC_BUS_TIMEOUT_EN
              cnt       <= '0;
`endif
              state     <= MEM;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= RESP;
            end
          end
        end
        MEM: begin
          // ack takes priority over an expiring watchdog on the same edge
          if (mem_ack) begin
            mem_req <= 1'b0;
            err_q   <= 1'b0;
            if (!mem_we) rdata_q <= mem_rdata;
            state   <= RESP;
          end
`ifdef SOC_BUS_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_ready = (state == RESP);
  assign cpu_err   = (state == RESP) && err_q;
  assign cpu_rdata = rdata_q;
  assign LED       = led_q;

endmodule
